// File: rtl/cmp_pkg.sv
// Shared types for the debounced magnitude comparator: relation code and channel FSM states.
package cmp_pkg;

  // Relation code laid out as {y, z}; NONE means no debounced result yet.
  typedef enum logic [1:0] {
    NONE = 2'b00,
    LT   = 2'b01,
    GT   = 2'b10,
    EQ   = 2'b11
  } rel_t;

  // Per-channel debounce FSM.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    LOCKED  = 2'b01,
    PENDING = 2'b10
  } state_t;

endpackage

// File: rtl/cmp_channel.sv
// One compare channel: classifies A against B, debounces the relation over
// STABLE_CNT consecutive agreeing samples and holds the result in flops.
module cmp_channel
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STABLE_CNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             y,
  output logic             z,
  output logic             changed,
  output logic             locked
);

  localparam int               CNT_W   = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg;
  rel_t             out_reg;
  rel_t             cand_reg;
  logic [CNT_W-1:0] count_reg;
  logic             changed_reg;

  rel_t             sample_rel;
  logic [CNT_W-1:0] count_bump;
  logic             take;

  assign take = en & in_valid;

  // Unsigned relation of the current operands.
  always_comb begin
    if (a > b) begin
      sample_rel = GT;
    end else if (a < b) begin
      sample_rel = LT;
    end else begin
      sample_rel = EQ;
    end
  end

  // Count the sample would produce: extend a matching run (saturating) or restart at one.
  always_comb begin
    count_bump = CNT_ONE;
    if (sample_rel == cand_reg) begin
      count_bump = (count_reg >= CNT_MAX) ? CNT_MAX : count_reg + CNT_ONE;
    end
  end

  // Debounce FSM; the output relation only moves when a candidate completes its run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= EMPTY;
      out_reg     <= NONE;
      cand_reg    <= NONE;
      count_reg   <= '0;
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= 1'b0;
      if (take) begin
        case (state_reg)
          LOCKED: begin
            if (sample_rel != out_reg) begin
              if (CNT_ONE == CNT_MAX) begin
                // Single-sample debounce: a differing sample is already a full run.
                out_reg     <= sample_rel;
                cand_reg    <= sample_rel;
                changed_reg <= 1'b1;
                count_reg   <= '0;
              end else begin
                state_reg <= PENDING;
                cand_reg  <= sample_rel;
                count_reg <= CNT_ONE;
              end
            end
          end
          EMPTY, PENDING: begin
            if (state_reg == PENDING && sample_rel == out_reg) begin
              // Glitch ended: fall back to the held result without a pulse.
              state_reg <= LOCKED;
              count_reg <= '0;
            end else if (count_bump == CNT_MAX) begin
              out_reg     <= sample_rel;
              cand_reg    <= sample_rel;
              changed_reg <= 1'b1;
              state_reg   <= LOCKED;
              count_reg   <= '0;
            end else begin
              cand_reg  <= sample_rel;
              count_reg <= count_bump;
            end
          end
          default: begin
            state_reg <= EMPTY;
            count_reg <= '0;
          end
        endcase
      end
    end
  end

  assign y       = out_reg[1];
  assign z       = out_reg[0];
  assign changed = changed_reg;
  assign locked  = (state_reg == LOCKED);

endmodule

// File: rtl/magnitude_compare_hold.sv
// Array of independent debounced magnitude comparators, one cmp_channel per lane.
module magnitude_compare_hold
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  output logic [CHANNELS-1:0]       y,
  output logic [CHANNELS-1:0]       z,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS-1:0]       locked
);

  // Lane gi uses operand slice [gi*WIDTH +: WIDTH] of a and b.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    cmp_channel #(
      .WIDTH      (WIDTH),
      .STABLE_CNT (STABLE_CNT)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .in_valid (in_valid[gi]),
      .a        (a[gi*WIDTH +: WIDTH]),
      .b        (b[gi*WIDTH +: WIDTH]),
      .y        (y[gi]),
      .z        (z[gi]),
      .changed  (changed[gi]),
      .locked   (locked[gi])
    );
  end

endmodule

// File: tb/tb_magnitude_compare_hold.sv
// Bench for magnitude_compare_hold: directed vector table, then random stimulus
// against a history-based model of the debounce rule.
module tb_magnitude_compare_hold;

  localparam int W = 8;
  localparam int C = 2;
  localparam int S = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [C-1:0]     in_valid;
  logic [C*W-1:0]   a;
  logic [C*W-1:0]   b;
  logic [C-1:0]     y;
  logic [C-1:0]     z;
  logic [C-1:0]     changed;
  logic [C-1:0]     locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  magnitude_compare_hold #(
    .WIDTH      (W),
    .CHANNELS   (C),
    .STABLE_CNT (S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .y        (y),
    .z        (z),
    .changed  (changed),
    .locked   (locked)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] v;
    logic [7:0] a0, b0, a1, b1;
    logic [1:0] ey, ez, ec, el;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic rst, input logic e, input logic [1:0] v,
                              input logic [7:0] a0, input logic [7:0] b0,
                              input logic [7:0] a1, input logic [7:0] b1,
                              input logic [1:0] ey, input logic [1:0] ez,
                              input logic [1:0] ec, input logic [1:0] el);
    vec_t r;
    r.rst = rst; r.en = e; r.v = v;
    r.a0 = a0; r.b0 = b0; r.a1 = a1; r.b1 = b1;
    r.ey = ey; r.ez = ez; r.ec = ec; r.el = el;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %b expected %b", name, idx, act, exp);
    end
  endtask

  // Apply one set of inputs across a rising edge; outputs are sampled 1ns later.
  task automatic drive(input logic rst, input logic e, input logic [1:0] v,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1);
    reset    = rst;
    en       = e;
    in_valid = v;
    a        = {a1, a0};
    b        = {b1, b0};
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] rel(input logic [7:0] x, input logic [7:0] w);
    if (x > w) return 2'b10;
    if (x < w) return 2'b01;
    return 2'b11;
  endfunction

  // Model: a channel's result changes to V when its last S samples since reset
  // are all V and V differs from the held result.
  logic [1:0] m_out  [C];
  logic [1:0] m_last [C];
  logic [1:0] m_hist [C][$];

  initial begin
    logic [1:0] ey, ez, ec, el;
    logic       r, e;
    logic [1:0] v;
    logic [7:0] av [C];
    logic [7:0] bv [C];

    reset = 1'b1; en = 1'b0; in_valid = '0; a = '0; b = '0;

    //                rst en  v      a0   b0  a1   b1    ey     ez     ec     el
    vecs[0]  = mk(1, 0, 2'b00,   0,   0,  0,   0, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[1]  = mk(0, 1, 2'b01,  20,  10,  0,   0, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[2]  = mk(0, 1, 2'b01,  20,  10,  0,   0, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[3]  = mk(0, 1, 2'b01,  20,  10,  0,   0, 2'b01, 2'b00, 2'b01, 2'b01);
    vecs[4]  = mk(0, 1, 2'b01,  20,  10,  0,   0, 2'b01, 2'b00, 2'b00, 2'b01);
    vecs[5]  = mk(0, 1, 2'b01,   5,   9,  0,   0, 2'b01, 2'b00, 2'b00, 2'b00);
    vecs[6]  = mk(0, 1, 2'b01,   5,   9,  0,   0, 2'b01, 2'b00, 2'b00, 2'b00);
    vecs[7]  = mk(0, 1, 2'b01,  20,  10,  0,   0, 2'b01, 2'b00, 2'b00, 2'b01);
    vecs[8]  = mk(0, 1, 2'b01,   7,   7,  0,   0, 2'b01, 2'b00, 2'b00, 2'b00);
    vecs[9]  = mk(0, 1, 2'b01,   3,   4,  0,   0, 2'b01, 2'b00, 2'b00, 2'b00);
    vecs[10] = mk(0, 1, 2'b01,   3,   4,  0,   0, 2'b01, 2'b00, 2'b00, 2'b00);
    vecs[11] = mk(0, 1, 2'b01,   3,   4,  0,   0, 2'b00, 2'b01, 2'b01, 2'b01);
    vecs[12] = mk(0, 1, 2'b01,   9,   1,  0,   0, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int i = 13; i < 18; i++)
      vecs[i] = mk(0, 0, 2'b11,  1, 200,  1, 200, 2'b00, 2'b01, 2'b00, 2'b00);
    vecs[18] = mk(0, 1, 2'b01,   9,   1,  0,   0, 2'b00, 2'b01, 2'b00, 2'b00);
    vecs[19] = mk(0, 1, 2'b01,   9,   1,  0,   0, 2'b01, 2'b00, 2'b01, 2'b01);
    vecs[20] = mk(0, 1, 2'b01,   1, 200,  0,   0, 2'b01, 2'b00, 2'b00, 2'b00);
    vecs[21] = mk(0, 1, 2'b01,   1, 200,  0,   0, 2'b01, 2'b00, 2'b00, 2'b00);
    vecs[22] = mk(1, 1, 2'b11,   1, 200,  1, 200, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[23] = mk(0, 1, 2'b01,   1, 200,  0,   0, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[24] = mk(0, 1, 2'b01,   1, 200,  0,   0, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[25] = mk(0, 1, 2'b01,   1, 200,  0,   0, 2'b00, 2'b01, 2'b01, 2'b01);
    vecs[26] = mk(0, 1, 2'b11,   9,   9, 255,  0, 2'b00, 2'b01, 2'b00, 2'b00);
    vecs[27] = mk(0, 1, 2'b11,   9,   9, 255,  0, 2'b00, 2'b01, 2'b00, 2'b00);
    vecs[28] = mk(0, 1, 2'b11,   9,   9, 255,  0, 2'b11, 2'b01, 2'b11, 2'b11);
    vecs[29] = mk(0, 0, 2'b11,   9,   9, 255,  0, 2'b11, 2'b01, 2'b00, 2'b11);

    // Directed table.
    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].v, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
      $display("vec %0d rst=%b en=%b v=%b -> y=%b z=%b changed=%b locked=%b",
               i, vecs[i].rst, vecs[i].en, vecs[i].v, y, z, changed, locked);
      check("vec_y",       i, y,       vecs[i].ey);
      check("vec_z",       i, z,       vecs[i].ez);
      check("vec_changed", i, changed, vecs[i].ec);
      check("vec_locked",  i, locked,  vecs[i].el);
    end

    // Random phase, starting from reset.
    for (int t = 0; t < 300; t++) begin
      r = (t == 0) || ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 4) != 0);
      v = 2'($urandom);
      for (int c = 0; c < C; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          av[c] = 8'($urandom);
          bv[c] = 8'($urandom);
        end else begin
          av[c] = 8'($urandom_range(0, 3));
          bv[c] = 8'($urandom_range(0, 3));
        end
      end
      drive(r, e, v, av[0], bv[0], av[1], bv[1]);

      ec = '0;
      for (int c = 0; c < C; c++) begin
        if (r) begin
          m_out[c]  = 2'b00;
          m_last[c] = 2'b00;
          m_hist[c].delete();
        end else if (e && v[c]) begin
          logic [1:0] s;
          logic       all_same;
          s = rel(av[c], bv[c]);
          m_hist[c].push_back(s);
          if (m_hist[c].size() > S) void'(m_hist[c].pop_front());
          all_same = (m_hist[c].size() == S);
          foreach (m_hist[c][k]) if (m_hist[c][k] != s) all_same = 1'b0;
          if (all_same && s != m_out[c]) begin
            m_out[c] = s;
            ec[c]    = 1'b1;
          end
          m_last[c] = s;
        end
        ey[c] = m_out[c][1];
        ez[c] = m_out[c][0];
        el[c] = (m_out[c] != 2'b00) && (m_last[c] == m_out[c]);
      end

      $display("rnd %0d rst=%b en=%b v=%b a=%h b=%h -> y=%b z=%b changed=%b locked=%b",
               t, r, e, v, a, b, y, z, changed, locked);
      check("rnd_y",       t, y,       ey);
      check("rnd_z",       t, z,       ez);
      check("rnd_changed", t, changed, ec);
      check("rnd_locked",  t, locked,  el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/magnitude_compare_hold.md
MAGNITUDE_COMPARE_HOLD -- requirements
Module: magnitude_compare_hold

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits, unsigned, minimum 1.
REQ-002 The block SHALL have parameter CHANNELS, default 4: number of independent compare channels, minimum 1.
REQ-003 The block SHALL have parameter STABLE_CNT, default 3: consecutive agreeing samples required before an output update, minimum 1.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port en, input, 1 bit: global enable; low freezes all state and outputs.
REQ-007 Port in_valid, input, CHANNELS bits: per-channel sample strobe.
REQ-008 Port a, input, CHANNELS x WIDTH: per-channel operand A, unsigned.
REQ-009 Port b, input, CHANNELS x WIDTH: per-channel operand B, unsigned.
REQ-010 Port y, output, CHANNELS bits: registered relation bit y (set when A >= B).
REQ-011 Port z, output, CHANNELS bits: registered relation bit z (set when A <= B).
REQ-012 Port changed, output, CHANNELS bits: one-cycle pulse when that channel's y/z update.
REQ-013 Port locked, output, CHANNELS bits: high while the channel holds a debounced result and no differing candidate is pending.

Function
REQ-014 The relation code SHALL be: A>B gives y=1,z=0; A<B gives y=0,z=1; A==B gives y=1,z=1; y=0,z=0 means no result yet.
REQ-015 Every y, z bit SHALL be driven from a flip-flop; the block SHALL infer no latches.
REQ-016 Each channel SHALL run its own FSM with states EMPTY, LOCKED, PENDING, plus a candidate register and a sample counter of width $clog2(STABLE_CNT+1).
REQ-017 A sample SHALL be taken for channel i only on an edge where en=1 and in_valid[i]=1; other edges leave that channel unchanged.
REQ-018 EMPTY/PENDING: a sample equal to the candidate SHALL increment the count; a sample differing from it SHALL load a new candidate with count=1.
REQ-019 When the count reaches STABLE_CNT, y/z SHALL take the candidate at that same edge, changed[i] SHALL pulse for the next cycle only, and the FSM SHALL enter LOCKED.
REQ-020 LOCKED: a sample equal to the current y/z SHALL keep the channel LOCKED; a differing sample SHALL enter PENDING with candidate=sample, count=1. With STABLE_CNT=1 it SHALL update directly.
REQ-021 PENDING: a sample equal to the current y/z SHALL return the channel to LOCKED, clear the count and leave y/z unchanged with no changed pulse.
REQ-022 Latency SHALL be exactly STABLE_CNT valid samples; outputs are visible the cycle after the completing edge.
REQ-023 en=0 SHALL dominate in_valid: counters, candidates, FSM state, y, z SHALL all hold and changed SHALL be 0.
REQ-024 The counter SHALL saturate at STABLE_CNT and never wrap.
REQ-025 locked[i] SHALL be 1 only in LOCKED.
REQ-026 Channels SHALL be fully independent; simultaneous updates on several channels SHALL all pulse changed in the same cycle.

Reset
REQ-027 While reset=1 at a rising edge, every channel SHALL go to EMPTY with y=0, z=0, changed=0, locked=0, count=0, candidate=none code; reset SHALL override en and in_valid.
REQ-028 Reset asserted mid-PENDING SHALL discard the partial count; the first post-reset sample starts at count=1.

Structure
REQ-029 Package cmp_pkg SHALL hold the relation enum rel_t (NONE=00, LT=01, GT=10, EQ=11 as {y,z}) and the state enum (EMPTY, LOCKED, PENDING).
REQ-030 Sub-module cmp_channel SHALL implement one channel (compare, FSM, counter) and be instantiated CHANNELS times via generate.

Verification (WIDTH=8, CHANNELS=2, STABLE_CNT=3)
REQ-031 Reset, then ch0 a=20,b=10 valid 3 consecutive edges -> y0/z0=1/0 after the third edge, changed[0] one cycle, locked[0]=1; ch1 stays 0/0.
REQ-032 Locked GT; samples a=5,b=9 twice then a=20,b=10 -> return to LOCKED, y/z stay 1/0, no changed pulse.
REQ-033 Samples a=7,b=7 then a=3,b=4 then a=3,b=4 x2 -> candidate restarts; LT (0/1) applied after the fourth sample.
REQ-034 en=0 for 5 cycles with in_valid=1 and a=1,b=200 -> all outputs and state frozen; counting resumes at previous count when en=1.
REQ-035 Reset asserted after 2 of 3 agreeing samples -> outputs 0/0; 3 further samples needed for update.
REQ-036 Both channels complete on the same edge (ch0 EQ 9/9, ch1 GT 255/0) -> changed=2'b11 for one cycle, y=2'b11, z=2'b01.
